// File: rtl/muldiv_engine.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine that owns the architectural HI/LO registers.
// The result is computed at launch and is held in pending registers until the countdown expires.
module muldiv_engine #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        start,
    input  logic [2:0]  MULT_DIV_OP,
    input  logic        MTHI,
    input  logic        MTLO,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [CNT_W-1:0] MULT_N  = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N   = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      resHi_q, resHi_d;
    logic [31:0]      resLo_q, resLo_d;
    logic             commit_q, commit_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic signed [63:0] prodS;
    logic [63:0]        prodU;
    logic [31:0]        divU, quoU, remU;
    logic [31:0]        absA, absB, quoMag, remMag, quoS, remS;
    logic [31:0]        opHi, opLo;
    logic               divByZero;

    // A zero divisor is replaced by 1 so the dividers never see it; that result is never committed.
    always_comb begin
        divByZero = (B == 32'd0);
        prodS     = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prodU     = {32'd0, A} * {32'd0, B};
        divU      = divByZero ? 32'd1 : B;
        quoU      = A / divU;
        remU      = A % divU;
        absA      = A[31] ? (32'd0 - A) : A;
        absB      = divByZero ? 32'd1 : (B[31] ? (32'd0 - B) : B);
        quoMag    = absA / absB;
        remMag    = absA % absB;
        quoS      = (A[31] ^ B[31]) ? (32'd0 - quoMag) : quoMag;
        remS      = A[31] ? (32'd0 - remMag) : remMag;
    end

    always_comb begin
        opHi = 32'd0;
        opLo = 32'd0;
        case (MULT_DIV_OP[1:0])
            2'd0: begin
                opHi = prodS[63:32];
                opLo = prodS[31:0];
            end
            2'd1: begin
                opHi = prodU[63:32];
                opLo = prodU[31:0];
            end
            2'd2: begin
                opHi = remS;
                opLo = quoS;
            end
            default: begin
                opHi = remU;
                opLo = quoU;
            end
        endcase
    end

    // A start in IDLE suppresses any simultaneous move; everything but the countdown is ignored in RUN.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        resHi_d  = resHi_q;
        resLo_d  = resLo_q;
        commit_d = commit_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (state_q == IDLE) begin
            if (start) begin
                if (!MULT_DIV_OP[2]) begin
                    state_d  = RUN;
                    cnt_d    = MULT_DIV_OP[1] ? DIV_N : MULT_N;
                    resHi_d  = opHi;
                    resLo_d  = opLo;
                    commit_d = !(MULT_DIV_OP[1] && divByZero);
                end
            end else begin
                if (MTHI) hi_d = A;
                if (MTLO) lo_d = A;
            end
        end else begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
                state_d = IDLE;
                if (commit_q) begin
                    hi_d = resHi_q;
                    lo_d = resLo_q;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            resHi_q  <= '0;
            resLo_q  <= '0;
            commit_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            resHi_q  <= resHi_d;
            resLo_q  <= resLo_d;
            commit_q <= commit_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy = (state_q == RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_muldiv_engine.sv
// Scoreboard bench for muldiv_engine: the stimulus pushes expected results, and a monitor
// pops one entry and compares it each time busy falls.
module tb_muldiv_engine;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        start = 1'b0;
    logic [2:0]  MULT_DIV_OP = '0;
    logic        MTHI = 1'b0;
    logic        MTLO = 1'b0;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t        expQ[$];
    int          compared = 0;
    int          mismatched = 0;
    logic [31:0] mHi = '0;
    logic [31:0] mLo = '0;

    muldiv_engine #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .A          (A),
        .B          (B),
        .start      (start),
        .MULT_DIV_OP(MULT_DIV_OP),
        .MTHI       (MTHI),
        .MTLO       (MTLO),
        .busy       (busy),
        .HI         (HI),
        .LO         (LO)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour from plain arithmetic; 64-bit signed math sidesteps the MIN/-1 overflow.
    function automatic logic [63:0] refResult(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] cur);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: return sa * sb;
            3'd1: return {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 32'd0) return cur;
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd3: begin
                if (b == 32'd0) return cur;
                return {a % b, a / b};
            end
            default: return cur;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic withMtlo);
        exp_t        e;
        logic [63:0] r;
        A           = a;
        B           = b;
        MULT_DIV_OP = op;
        start       = 1'b1;
        MTLO        = withMtlo;
        r           = refResult(op, a, b, {mHi, mLo});
        mHi         = r[63:32];
        mLo         = r[31:0];
        e.hi        = mHi;
        e.lo        = mLo;
        e.cycles    = op[1] ? DIV_CYCLES : MULT_CYCLES;
        expQ.push_back(e);
        tick();
        start = 1'b0;
        MTLO  = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        if (busy) checkOutput("idle_timeout", busy, 0);
    endtask

    task automatic moveWrite(input logic hi, input logic lo, input logic [31:0] a);
        A    = a;
        MTHI = hi;
        MTLO = lo;
        tick();
        MTHI = 1'b0;
        MTLO = 1'b0;
        if (hi) mHi = a;
        if (lo) mLo = a;
        checkOutput("mt_HI", HI, mHi);
        checkOutput("mt_LO", LO, mLo);
    endtask

    // Monitor: measures each busy period and checks it plus HI/LO against the oldest expectation.
    initial begin
        exp_t e;
        logic prevBusy = 1'b0;
        int   busyCnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prevBusy = 1'b0;
                busyCnt  = 0;
            end else begin
                if (busy) begin
                    busyCnt++;
                end else if (prevBusy) begin
                    if (expQ.size() == 0) begin
                        checkOutput("busy_without_op", busyCnt, 0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("busy_len", busyCnt, e.cycles);
                        checkOutput("res_HI", HI, e.hi);
                        checkOutput("res_LO", LO, e.lo);
                    end
                    busyCnt = 0;
                end
                prevBusy = busy;
            end
        end
    end

    initial begin
        logic [31:0] ra, rb;
        int          sel;

        #1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_HI", HI, 0);
        checkOutput("reset_LO", LO, 0);
        tick();
        reset = 1'b0;
        tick();

        applyStimulus(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
        waitIdle();
        applyStimulus(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        waitIdle();

        applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        waitIdle();
        applyStimulus(3'd3, 32'd7, 32'd2, 1'b0);
        waitIdle();

        moveWrite(1'b1, 1'b0, 32'h1111_1111);
        moveWrite(1'b0, 1'b1, 32'h2222_2222);
        applyStimulus(3'd3, 32'd5, 32'd0, 1'b0);
        waitIdle();
        applyStimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        waitIdle();

        // Launch a MULT, then try to disturb it with operand changes, a DIV start and an MTHI.
        applyStimulus(3'd0, 32'd2, 32'd3, 1'b0);
        A           = 32'd99;
        B           = 32'd7;
        MULT_DIV_OP = 3'd2;
        start       = 1'b1;
        tick();
        start = 1'b0;
        MTHI  = 1'b1;
        A     = 32'hDEAD_BEEF;
        tick();
        MTHI = 1'b0;
        waitIdle();
        repeat (4) begin
            tick();
            checkOutput("no_extra_busy", busy, 0);
        end

        moveWrite(1'b1, 1'b0, 32'h1234_5678);
        applyStimulus(3'd1, 32'd4, 32'd4, 1'b1);
        waitIdle();

        // Randomised ops back to back, with moves and reserved opcodes mixed in.
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            if (sel <= 6) begin
                applyStimulus(3'($urandom_range(0, 3)), ra, rb, 1'b0);
                waitIdle();
            end else if (sel == 7) begin
                moveWrite(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra);
            end else begin
                A           = ra;
                B           = rb;
                MULT_DIV_OP = 3'($urandom_range(4, 7));
                start       = 1'b1;
                tick();
                start = 1'b0;
                checkOutput("reserved_busy", busy, 0);
                checkOutput("reserved_HI", HI, mHi);
                checkOutput("reserved_LO", LO, mLo);
            end
        end

        // Asynchronous reset in the middle of a DIV must clear everything and drop the pending result.
        moveWrite(1'b1, 1'b1, 32'hAAAA_5555);
        applyStimulus(3'd2, 32'd100, 32'd7, 1'b0);
        repeat (3) tick();
        #1;
        reset = 1'b1;
        expQ.delete();
        mHi = '0;
        mLo = '0;
        #1;
        checkOutput("async_busy", busy, 0);
        checkOutput("async_HI", HI, 0);
        checkOutput("async_LO", LO, 0);
        tick();
        tick();
        reset = 1'b0;
        repeat (15) begin
            tick();
            checkOutput("post_reset_busy", busy, 0);
        end
        checkOutput("post_reset_HI", HI, 0);
        checkOutput("post_reset_LO", LO, 0);

        repeat (2) tick();
        checkOutput("queue_empty", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
